// File: rtl/router_pkg.sv
// Shared constants for the router ingress control path: state encoding,
// address geometry and a helper that picks one port's flag by address.
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    localparam logic [2:0] DA  = 3'd0;
    localparam logic [2:0] LFD = 3'd1;
    localparam logic [2:0] LD  = 3'd2;
    localparam logic [2:0] FFS = 3'd3;
    localparam logic [2:0] LAF = 3'd4;
    localparam logic [2:0] LP  = 3'd5;
    localparam logic [2:0] CPE = 3'd6;
    localparam logic [2:0] WTE = 3'd7;

    // The invalid address selects no port, so its flag reads as 0.
    function automatic logic port_bit(input logic [NUM_PORTS-1:0] flags,
                                      input logic [ADDR_W-1:0]    addr);
        return (addr != ADDR_INVALID) ? flags[addr] : 1'b0;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Status inputs and capture strobes between the router control FSM and
// the register block / synchronizer.
interface router_fsm_if;
    import router_pkg::*;

    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic              fifo_empty_0;
    logic              fifo_empty_1;
    logic              fifo_empty_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;
    logic              parity_done;
    logic              low_pkt_valid;

    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              busy;

    modport master (
        output pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

endinterface

// File: rtl/router_fsm.sv
// Control sequencer for the 1x3 router ingress path: tracks packet phase,
// stalls on FIFO full and emits Moore capture strobes.
module router_fsm
    import router_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    router_fsm_if.slave  bus
);

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [ADDR_W-1:0]    addr_q;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] soft_rst;
    logic                 addr_ok;

    assign empty    = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_rst = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign addr_ok  = bus.pkt_valid && (bus.data_in != ADDR_INVALID);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= DA;
            addr_q <= ADDR_INVALID;
        end else begin
            state <= next_state;
            if (state == DA && addr_ok)
                addr_q <= bus.data_in;
        end
    end

    // A read timeout on the packet's own port aborts it from any busy state.
    always_comb begin
        next_state = state;
        if (state != DA && port_bit(soft_rst, addr_q)) begin
            next_state = DA;
        end else begin
            case (state)
                DA:  if (addr_ok)
                         next_state = port_bit(empty, bus.data_in) ? LFD : WTE;
                LFD: next_state = LD;
                LD:  if (bus.fifo_full)       next_state = FFS;
                     else if (!bus.pkt_valid) next_state = LP;
                FFS: if (!bus.fifo_full)      next_state = LAF;
                LAF: if (bus.parity_done)        next_state = DA;
                     else if (bus.low_pkt_valid) next_state = LP;
                     else                        next_state = LD;
                LP:  next_state = CPE;
                CPE: next_state = bus.fifo_full ? FFS : DA;
                WTE: if (port_bit(empty, addr_q)) next_state = LFD;
                default: next_state = DA;
            endcase
        end
    end

    assign bus.detect_add    = (state == DA);
    assign bus.lfd_state     = (state == LFD);
    assign bus.ld_state      = (state == LD);
    assign bus.laf_state     = (state == LAF);
    assign bus.full_state    = (state == FFS);
    assign bus.rst_int_reg   = (state == CPE);
    assign bus.write_enb_reg = (state == LD) || (state == LP) || (state == LAF);
    assign bus.busy          = (state != DA) && (state != LD);

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: directed packet scenarios plus random
// input traffic, checked against a phase-level reference model.
module tb_router_fsm;

    logic clock = 1'b0;
    logic reset;

    router_fsm_if bus ();

    router_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef enum int { P_ADDR, P_HEAD, P_DATA, P_STALL, P_RESUME,
                       P_PARITY, P_CHECK, P_WAIT } phase_t;

    typedef struct {
        logic [7:0] outs;
        phase_t     ph;
        int         tick;
    } exp_t;

    exp_t   sb[$];
    phase_t m_ph;
    int     m_addr;
    int     tick_no = 0;
    int     checks  = 0;
    int     errors  = 0;

    // Expected strobes: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    function automatic logic [7:0] strobes(input phase_t p);
        logic [7:0] v;
        v = 8'b0;
        case (p)
            P_ADDR:   v = 8'b1000_0000;
            P_HEAD:   v = 8'b0100_0001;
            P_DATA:   v = 8'b0010_0100;
            P_RESUME: v = 8'b0001_0101;
            P_STALL:  v = 8'b0000_1001;
            P_PARITY: v = 8'b0000_0101;
            P_CHECK:  v = 8'b0000_0011;
            P_WAIT:   v = 8'b0000_0001;
            default:  v = 8'b0;
        endcase
        return v;
    endfunction

    // Advance the model one clock using the inputs currently applied, queue the
    // strobes the DUT must show after that edge, then move past the edge.
    task automatic tick();
        bit emp[4];
        bit srs[4];
        emp = '{bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2, 1'b0};
        srs = '{bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2, 1'b0};
        if (reset) begin
            m_ph   = P_ADDR;
            m_addr = 3;
        end else if (m_ph != P_ADDR && srs[m_addr]) begin
            m_ph = P_ADDR;
        end else begin
            case (m_ph)
                P_ADDR:
                    if (bus.pkt_valid && int'(bus.data_in) != 3) begin
                        m_addr = int'(bus.data_in);
                        m_ph   = emp[m_addr] ? P_HEAD : P_WAIT;
                    end
                P_HEAD:   m_ph = P_DATA;
                P_DATA:   m_ph = bus.fifo_full ? P_STALL : (!bus.pkt_valid ? P_PARITY : P_DATA);
                P_STALL:  m_ph = bus.fifo_full ? P_STALL : P_RESUME;
                P_RESUME: m_ph = bus.parity_done ? P_ADDR : (bus.low_pkt_valid ? P_PARITY : P_DATA);
                P_PARITY: m_ph = P_CHECK;
                P_CHECK:  m_ph = bus.fifo_full ? P_STALL : P_ADDR;
                P_WAIT:   m_ph = emp[m_addr] ? P_HEAD : P_WAIT;
                default:  m_ph = P_ADDR;
            endcase
        end
        tick_no++;
        sb.push_back('{outs: strobes(m_ph), ph: m_ph, tick: tick_no});
        @(posedge clock);
        #3;
    endtask

    task automatic idle();
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'b00;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: the DUT presents strobes every cycle; sample 2 time units after the edge.
    initial begin : monitor
        logic [7:0] got;
        exp_t       e;
        forever begin
            @(posedge clock);
            #2;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                       bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
                checks++;
                if (got !== e.outs) begin
                    errors++;
                    $display("FAIL strobes tick %0d phase %s: got %b expected %b",
                             e.tick, e.ph.name(), got, e.outs);
                end
            end
        end
    end

    initial begin : stimulus
        idle();
        reset  = 1'b1;
        m_ph   = P_ADDR;
        m_addr = 3;
        ticks(2);
        reset = 1'b0;
        ticks(2);

        // Reset while mid-packet in the payload phase.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b01;
        ticks(3);
        reset = 1'b1;
        ticks(2);
        reset = 1'b0; idle();
        ticks(2);

        // Address 1, empty FIFO, 4 payload bytes then parity.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b01;
        ticks(5);
        bus.pkt_valid = 1'b0;
        ticks(4);

        // Address 2 with its FIFO not empty: wait, then empty rises.
        bus.fifo_empty_2 = 1'b0;
        bus.pkt_valid = 1'b1; bus.data_in = 2'b10;
        tick();
        ticks(4);
        bus.fifo_empty_2 = 1'b1;
        ticks(3);
        bus.pkt_valid = 1'b0;
        ticks(4);

        // Full during the 3rd payload byte, resume, then pkt_valid low via low_pkt_valid.
        idle();
        bus.pkt_valid = 1'b1; bus.data_in = 2'b00;
        ticks(3);
        bus.fifo_full = 1'b1;
        ticks(4);
        bus.fifo_full = 1'b0;
        ticks(2);
        bus.fifo_full = 1'b1;
        tick();
        bus.fifo_full = 1'b0;
        bus.pkt_valid = 1'b0; bus.low_pkt_valid = 1'b1;
        tick();
        bus.low_pkt_valid = 1'b0;
        ticks(4);

        // Soft reset of another port is ignored; own port's soft reset aborts.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b00;
        ticks(3);
        bus.fifo_full = 1'b1;
        ticks(2);
        bus.soft_reset_1 = 1'b1;
        tick();
        bus.soft_reset_1 = 1'b0;
        ticks(2);
        bus.soft_reset_0 = 1'b1;
        tick();
        idle();
        ticks(2);

        // Invalid address header is ignored; a following packet still decodes.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b11;
        ticks(3);
        bus.fifo_empty_0 = 1'b0;
        bus.soft_reset_0 = 1'b1;
        ticks(2);
        bus.pkt_valid = 1'b0; bus.soft_reset_0 = 1'b0;
        tick();
        bus.pkt_valid = 1'b1; bus.data_in = 2'b01;
        ticks(3);
        idle();
        ticks(6);

        // Random traffic across every input.
        for (int i = 0; i < 3000; i++) begin
            reset             = ($urandom_range(0, 63) == 0);
            bus.pkt_valid     = ($urandom_range(0, 3) != 0);
            bus.data_in       = 2'($urandom_range(0, 3));
            bus.fifo_full     = ($urandom_range(0, 3) == 0);
            bus.fifo_empty_0  = 1'($urandom_range(0, 1));
            bus.fifo_empty_1  = 1'($urandom_range(0, 1));
            bus.fifo_empty_2  = 1'($urandom_range(0, 1));
            bus.soft_reset_0  = ($urandom_range(0, 15) == 0);
            bus.soft_reset_1  = ($urandom_range(0, 15) == 0);
            bus.soft_reset_2  = ($urandom_range(0, 15) == 0);
            bus.parity_done   = ($urandom_range(0, 3) == 0);
            bus.low_pkt_valid = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1'b0; idle();
        ticks(2);

        @(posedge clock);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
